// File: rtl/sha_host_bridge_pkg.sv
// sha_bridge_pkg: shared state encoding, digest geometry and address type for the SHA host bridge
package sha_bridge_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, READ, SEND} bridge_state_e;
  localparam int DIGEST_WORDS = 8;
  localparam int DIGEST_IDX_W = $clog2(DIGEST_WORDS);
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;
  typedef logic [15:0] addr_t;
  typedef logic [DIGEST_IDX_W-1:0] digest_idx_t;
endpackage

// File: rtl/sha_host_bridge_if.sv
// sha_host_bridge_if: message-in and digest-out valid/ready streams of the host bridge
interface sha_host_bridge_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/sha_digest_buffer.sv
// sha_digest_buffer: captures digest words by index, then streams them out with a last flag
module sha_digest_buffer
  import sha_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cap_en,
  input  digest_idx_t cap_idx,
  input  logic [31:0] cap_data,
  input  logic        send,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  input  logic        out_ready
);
  logic [31:0] word_q [DIGEST_WORDS];
  logic [31:0] word_d [DIGEST_WORDS];
  digest_idx_t ptr_q, ptr_d;
  logic valid_q, valid_d;
  always_comb begin
    word_d = word_q;
    if (cap_en) word_d[cap_idx] = cap_data;
    ptr_d = send ? '0 : ptr_q + digest_idx_t'(valid_q && out_ready);
    valid_d = send || (valid_q && !(out_ready && out_last));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q <= ptr_d;
    end
  end
  always_ff @(posedge clk) word_q <= word_d;
  // data is forced to zero while idle so stale digest words never reach the sink
  assign out_valid = valid_q;
  assign out_data = valid_q ? word_q[ptr_q] : '0;
  assign out_last = valid_q && ptr_q == digest_idx_t'(DIGEST_WORDS - 1);
endmodule

// File: rtl/sha_host_bridge.sv
// sha_host_bridge: loads a message into shared memory, runs the hasher, reads back and streams the digest
module sha_host_bridge
  import sha_bridge_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  sha_host_bridge_if.slave io,
  input  addr_t       message_addr,
  input  addr_t       output_addr,
  output logic        hash_start,
  input  logic        hash_done,
  output logic        mem_sel_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output addr_t       mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        timeout_err
);
  bridge_state_e state_q, state_d;
  addr_t idx_q, idx_d, msg_base_q, msg_base_d, out_base_q, out_base_d, addr_q, addr_d;
  logic [3:0] rd_q, rd_d;
  logic [31:0] to_q, to_d, wdata_q, wdata_d;
  logic we_q, we_d, start_q, start_d, sel_q, sel_d, terr_q, terr_d;
  logic accept, to_hit;
  assign accept = state_q == LOAD && io.in_valid;
  assign to_hit = to_q + 32'd1 == 32'(TIMEOUT_CYCLES);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rd_d = rd_q;
    to_d = to_q;
    msg_base_d = msg_base_q;
    out_base_d = out_base_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    start_d = 1'b0;
    sel_d = sel_q;
    terr_d = terr_q;
    case (state_q)
      IDLE: if (io.in_valid) begin
        msg_base_d = message_addr;
        out_base_d = output_addr;
        terr_d = 1'b0;
        idx_d = '0;
        state_d = LOAD;
      end
      LOAD: if (accept) begin
        we_d = 1'b1;
        addr_d = msg_base_q + idx_q;
        wdata_d = io.in_data;
        idx_d = idx_q + 16'd1;
        state_d = idx_q == addr_t'(NUM_OF_WORDS - 1) ? START : LOAD;
      end
      START: begin
        start_d = 1'b1;
        sel_d = 1'b1;
        to_d = '0;
        state_d = WAIT_BUSY;
      end
      // WAIT_BUSY guards against done still being high before the hasher leaves its idle state
      WAIT_BUSY, WAIT_DONE: begin
        to_d = to_q + 32'd1;
        if (to_hit) begin
          terr_d = 1'b1;
          sel_d = 1'b0;
          state_d = IDLE;
        end else if (state_q == WAIT_BUSY && !hash_done) begin
          state_d = WAIT_DONE;
        end else if (state_q == WAIT_DONE && hash_done) begin
          sel_d = 1'b0;
          rd_d = '0;
          state_d = READ;
        end
      end
      // addresses go out for DIGEST_WORDS cycles; read data trails its address by two edges
      READ: begin
        rd_d = rd_q + 4'd1;
        addr_d = rd_q < 4'(DIGEST_WORDS) ? out_base_q + addr_t'(rd_q) : addr_q;
        state_d = rd_q == 4'(DIGEST_WORDS + 1) ? SEND : READ;
      end
      SEND: state_d = io.out_valid && io.out_ready && io.out_last ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      rd_q <= '0;
      to_q <= '0;
      msg_base_q <= '0;
      out_base_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      sel_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rd_q <= rd_d;
      to_q <= to_d;
      msg_base_q <= msg_base_d;
      out_base_q <= out_base_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      sel_q <= sel_d;
      terr_q <= terr_d;
    end
  end
  sha_digest_buffer u_buf (
    .clk(clk),
    .reset(reset),
    .cap_en(state_q == READ && rd_q >= 4'd2),
    .cap_idx(digest_idx_t'(rd_q - 4'd2)),
    .cap_data(mem_read_data),
    .send(state_q == READ && rd_q == 4'(DIGEST_WORDS + 1)),
    .out_valid(io.out_valid),
    .out_data(io.out_data),
    .out_last(io.out_last),
    .out_ready(io.out_ready)
  );
  assign io.in_ready = state_q == LOAD;
  assign busy = state_q != IDLE;
  assign hash_start = start_q;
  assign mem_sel_hash = sel_q;
  assign mem_clk = clk;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_write_data = wdata_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_sha_host_bridge.sv
// tb_sha_host_bridge: scoreboard bench with a memory model and a hasher stub behind the port mux
module tb_sha_host_bridge;
  import sha_bridge_pkg::*;
  localparam int NW = 20;
  localparam int TO = 4096;
  logic clk = 1'b0, reset = 1'b1;
  addr_t message_addr, output_addr, mem_addr, out_base, stub_addr;
  logic hash_start, hash_done, mem_sel_hash, mem_clk, mem_we, busy, timeout_err, stub_we;
  logic [31:0] mem_write_data, mem_read_data, stub_data, dig_base;
  logic [31:0] mem [65536];
  logic [32:0] exp_q [$];
  int errors = 0, checks = 0, cyc = 0, last_we_cyc = -10, start_cnt = 0, start_cyc = 0, terr_cyc = 0;
  int stub_mode = 0, out_mode = 0, rc = 0;
  logic prev_acc = 1'b0, stall = 1'b0, last_hs = 1'b0, terr_prev = 1'b0, st_last = 1'b0;
  logic [31:0] st_data = '0;
  always #5 clk = ~clk;
  sha_host_bridge_if bif();
  sha_host_bridge #(.NUM_OF_WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .io(bif), .message_addr(message_addr), .output_addr(output_addr),
    .hash_start(hash_start), .hash_done(hash_done), .mem_sel_hash(mem_sel_hash), .mem_clk(mem_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy), .timeout_err(timeout_err)
  );
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  // shared synchronous memory behind the top-level port mux
  always @(posedge clk) begin
    if (mem_sel_hash ? stub_we : mem_we) mem[mem_sel_hash ? stub_addr : mem_addr] <= mem_sel_hash ? stub_data : mem_write_data;
    mem_read_data <= mem[mem_sel_hash ? stub_addr : mem_addr];
  end
  // monitor: protocol invariants and scoreboard pops on every digest handshake
  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    check("mem_we_follows_accept", mem_we, prev_acc);
    if (mem_we) last_we_cyc = cyc;
    if (hash_start) begin
      start_cnt++;
      start_cyc = cyc;
      check("start_after_last_write", cyc, last_we_cyc + 1);
    end
    if (timeout_err && !terr_prev) terr_cyc = cyc;
    if (stall) begin
      check("stall_valid", out_valid_w(), 1);
      check("stall_data", bif.out_data, st_data);
      check("stall_last", bif.out_last, st_last);
    end
    if (last_hs) check("busy_after_last", busy, 0);
    if (bif.out_valid && bif.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h expected no word", bif.out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", bif.out_data, e[31:0]);
        check("out_last", bif.out_last, 32'(e[32]));
      end
    end
    stall = bif.out_valid && !bif.out_ready;
    st_data = bif.out_data;
    st_last = bif.out_last;
    last_hs = bif.out_valid && bif.out_ready && bif.out_last;
    terr_prev = timeout_err;
    prev_acc = bif.in_valid && bif.in_ready && !reset;
  end
  function automatic logic out_valid_w();
    return bif.out_valid;
  endfunction
  // hasher stub: done drops one cycle after start, digest written, done rises 50 cycles after the drop
  initial begin
    stub_we = 1'b0;
    stub_addr = '0;
    stub_data = '0;
    hash_done = 1'b1;
    forever begin
      @(negedge clk);
      if (hash_start && stub_mode == 0) begin
        @(posedge clk);
        #1 hash_done = 1'b0;
        for (int c = 1; c <= 50; c++) begin
          @(posedge clk);
          #1;
          stub_we = c <= DIGEST_WORDS;
          stub_addr = out_base + addr_t'(c - 1);
          stub_data = dig_base + 32'(c - 1);
          if (c == 50) hash_done = 1'b1;
        end
      end
    end
  end
  initial begin
    bif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      bif.out_ready = out_mode == 0 || rc % 3 == 0;
    end
  end
  task automatic send_words(input int n, input logic [31:0] base, input bit gaps);
    int i = 0, guard = 0;
    bit gap;
    while (i < n && guard < 2000) begin
      @(posedge clk);
      #1;
      gap = gaps && $urandom_range(0, 2) == 0;
      bif.in_valid = !gap;
      bif.in_data = base + 32'(i);
      @(negedge clk);
      if (!gap && bif.in_ready) i++;
      guard++;
    end
    @(posedge clk);
    #1 bif.in_valid = 1'b0;
    check("words_accepted", i, n);
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    @(negedge clk);
    while (busy && k < lim) begin
      @(negedge clk);
      k++;
    end
    check("job_finished_in_time", busy, 0);
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, bif.in_ready, 0);
    check({tag, "_out_valid"}, bif.out_valid, 0);
    check({tag, "_out_data"}, bif.out_data, 0);
    check({tag, "_out_last"}, bif.out_last, 0);
    check({tag, "_hash_start"}, hash_start, 0);
    check({tag, "_mem_sel_hash"}, mem_sel_hash, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_write_data, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask
  task automatic run_job(input addr_t ma, input addr_t oa, input logic [31:0] mbase, input logic [31:0] dbase, input bit gaps);
    int s0 = start_cnt;
    addr_t a;
    message_addr = ma;
    output_addr = oa;
    out_base = oa;
    dig_base = dbase;
    for (int k = 0; k < DIGEST_WORDS; k++) exp_q.push_back({k == DIGEST_WORDS - 1, dbase + 32'(k)});
    send_words(NW, mbase, gaps);
    @(negedge clk);
    @(negedge clk);
    check("timeout_err_cleared", timeout_err, 0);
    for (int i = 0; i < NW; i++) begin
      a = ma + addr_t'(i);
      check("mem_message", mem[a], mbase + 32'(i));
    end
    wait_idle(1000);
    check("start_pulses", start_cnt - s0, 1);
    check("digest_drained", exp_q.size(), 0);
  endtask
  initial begin
    int s0, k;
    bif.in_valid = 1'b0;
    bif.in_data = '0;
    message_addr = '0;
    output_addr = '0;
    out_base = '0;
    dig_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1 reset = 1'b0;
    run_job(16'h0000, 16'h0100, 32'h1000_0000, 32'hA000_0000, 1'b0);
    out_mode = 1;
    run_job(16'h0200, 16'h0300, 32'h2000_0000, 32'hC000_0000, 1'b1);
    out_mode = 0;
    stub_mode = 1;
    message_addr = 16'h0600;
    output_addr = 16'h0700;
    s0 = start_cnt;
    send_words(NW, 32'h3000_0000, 1'b0);
    k = 0;
    @(negedge clk);
    while (!timeout_err && k < TO + 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_latency", terr_cyc - start_cyc, TO);
    check("timeout_idle", busy, 0);
    check("timeout_mem_sel", mem_sel_hash, 0);
    check("timeout_start_pulses", start_cnt - s0, 1);
    repeat (5) @(negedge clk);
    check("timeout_no_out_valid", bif.out_valid, 0);
    stub_mode = 0;
    run_job(16'hFFFE, 16'hFFFC, 32'h5000_0000, 32'hE000_0000, 1'b0);
    message_addr = 16'h0400;
    output_addr = 16'h0500;
    send_words(5, 32'h6000_0000, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_quiet("abort");
    @(posedge clk);
    #1 reset = 1'b0;
    run_job(16'h0400, 16'h0500, 32'h4000_0000, 32'hD000_0000, 1'b0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end
endmodule

// File: doc/sha_host_bridge.md
Name: sha_host_bridge

Overview:
- Host-side counterpart to the simplified SHA-256 core, driving the other end of its start/done handshake and its shared word memory.
- Loads a NUM_OF_WORDS-word message from a valid/ready input stream into memory at message_addr.
- Pulses start to the hasher, waits for its done handshake, then reads the 8-word digest back from output_addr.
- Streams the digest out on a valid/ready output with a last flag; owns the memory port except while the hasher runs.

Parameters:
NUM_OF_WORDS, 20, message length in 32-bit words (1..65535); must equal the hasher's NUM_OF_WORDS
DIGEST_WORDS, 8, digest words read back
TIMEOUT_CYCLES, 4096, maximum cycles from start pulse to done high

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  message word valid
in_data  in  32  message word
in_ready  out  1  bridge accepts word
out_valid  out  1  digest word valid
out_data  out  32  digest word
out_last  out  1  marks digest word 7
out_ready  in  1  sink accepts digest word
message_addr  in  16  message base word address
output_addr  in  16  digest base word address
hash_start  out  1  one-cycle start pulse to hasher
hash_done  in  1  hasher done (high while hasher idle)
mem_sel_hash  out  1  1 = top-level mux gives memory port to hasher
mem_clk  out  1  equals clk
mem_we  out  1  memory write enable
mem_addr  out  16  memory word address
mem_write_data  out  32  memory write data
mem_read_data  in  32  memory read data (synchronous, 1-cycle)
busy  out  1  state != IDLE
timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; all outputs 0 except mem_clk; counters 0; digest buffer contents don't-care. Reset mid-operation abandons the job with no partial digest output.
- All memory outputs are registered. All address arithmetic is 16-bit modulo (wraps FFFF->0000).
- IDLE:
  - in_ready=0.
  - When in_valid=1: latch message_addr and output_addr, clear timeout_err, go to LOAD.
- LOAD:
  - in_ready=1.
  - On each accept: mem_we<=1, mem_addr<=msg_base+idx, mem_write_data<=in_data, idx++.
  - A cycle without accept registers mem_we<=0.
  - The edge that accepts word NUM_OF_WORDS-1 goes to START; that write still occurs on the next cycle.
- START:
  - Exactly one cycle: mem_we=0, hash_start=1, mem_sel_hash=1.
  - Timeout counter cleared.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for hash_done=0, then go to WAIT_DONE.
  - This guards against the hasher's done being high before it leaves IDLE.
- WAIT_DONE:
  - Wait for hash_done=1, then mem_sel_hash<=0 and go to READ.
- Timeout: the counter increments in WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT_CYCLES: timeout_err<=1, mem_sel_hash<=0, go to IDLE.
- READ:
  - Issue mem_addr = out_base+0..7 on 8 consecutive cycles, mem_we=0.
  - Data for the address registered at edge k is sampled from mem_read_data at edge k+2 into digest[k].
  - After digest[7] is captured (10 cycles in READ), go to SEND.
- SEND:
  - out_valid=1, out_data=digest[ptr], out_last=(ptr==7).
  - On out_valid&out_ready: ptr++.
  - out_data and out_last are held stable while out_ready=0.
  - After the word-7 handshake: out_valid<=0, go to IDLE.
  - out_valid never drops before its handshake completes.
- in_valid outside LOAD is ignored (in_ready=0). hash_done changes outside the WAIT states are ignored.
- Throughput: one message word per cycle in LOAD; one digest word per cycle in SEND when out_ready stays high.

Decomposition:
- Package sha_bridge_pkg holds:
  - bridge state enum {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, READ, SEND}
  - DIGEST_WORDS = 8
  - default TIMEOUT_CYCLES
  - 16-bit address typedef
- One natural sub-module, sha_digest_buffer: 8x32 capture-by-index plus valid/ready stream-out with last.
- The FSM, counters and memory port stay in sha_host_bridge.

Test Plan:
1. Load with NUM_OF_WORDS=20, message_addr=0x0000, in_data=0x10000000+i, in_valid always high -> memory model holds 0x10000000..0x10000013 at 0x0000..0x0013; hash_start one cycle after last write; exactly one start pulse.
2. Hasher stub: done drops 1 cycle after start, rises 50 cycles later, and writes 0xA0000000+k at 0x0100+k (output_addr=0x0100) -> out_data 0xA0000000..0xA0000007 in order, out_last only on 0xA0000007, busy falls after the last handshake.
3. Backpressure: out_ready toggles 1,0,0,1,... and in_valid has random gaps -> no lost or duplicated words; out_data stable during stalls; mem_we=0 on gap cycles.
4. TIMEOUT_CYCLES=16, stub keeps done=1 forever -> timeout_err=1 at the 16th WAIT_BUSY cycle, state IDLE, mem_sel_hash=0, no out_valid; next job clears timeout_err.
5. Reset asserted after 5 accepted words -> all outputs 0 next cycle; the following job writes from message_addr+0 and completes normally.
6. message_addr=0xFFFE, NUM_OF_WORDS=4 -> writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001; output_addr=0xFFFC -> digest reads wrap identically.
